// File: rtl/response_resolver_if.sv
// Responder handshake bundle: the resolver (master) presents one responder address
// at a time, and the consumer (slave) accepts it with resp_ready.
interface response_resolver_if #(
    parameter int addr_bits = 7
);
    logic                 resp_valid;
    logic                 resp_ready;
    logic [addr_bits-1:0] resp_addr;
    logic                 resp_last;

    modport master (
        output resp_valid,
        output resp_addr,
        output resp_last,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_addr,
        input  resp_last,
        output resp_ready
    );
endinterface

// File: rtl/response_resolver.sv
// Multiple-response resolver: snapshots the CAPP tag bits and returns the tagged cells
// one per cycle, lowest index first. Optional macro RESOLVER_COUNT_EN adds resp_count.
//
// state | meaning
// IDLE  | waiting for start; pending is empty
// ISSUE | presenting the lowest pending responder on the handshake
// DONE  | one-cycle completion pulse, then back to IDLE
module response_resolver #(
    parameter int num_cells = 100,
    parameter int addr_bits = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [num_cells-1:0] tag_wires,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 none,
`ifdef RESOLVER_COUNT_EN
    output logic [addr_bits:0]   resp_count,
`endif
    response_resolver_if.master  resp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [num_cells-1:0] one_c = num_cells'(1);

    state_t               state, state_nxt;
    logic [num_cells-1:0] pending, pending_nxt;
    logic                 none_nxt;
    logic [num_cells-1:0] low_bit;
    logic                 single;
    logic [addr_bits-1:0] first_idx;
    logic                 handshake;

    // Isolating the lowest set bit keeps the clear mask independent of the encoder.
    assign low_bit   = pending & (~pending + one_c);
    assign single    = (pending != '0) && ((pending & (pending - one_c)) == '0);
    assign handshake = (state == ISSUE) && resp.resp_ready;

    always_comb begin
        first_idx = '0;
        for (int i = num_cells - 1; i >= 0; i--) begin
            if (pending[i]) first_idx = addr_bits'(i);
        end
    end

`ifdef RESOLVER_COUNT_EN
    logic [addr_bits:0] tag_popcount;
    logic [addr_bits:0] count_nxt;

    always_comb begin
        tag_popcount = '0;
        for (int i = 0; i < num_cells; i++) begin
            tag_popcount = tag_popcount + {{addr_bits{1'b0}}, tag_wires[i]};
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            pending <= '0;
            none    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            none    <= none_nxt;
        end
    end

`ifdef RESOLVER_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST) resp_count <= '0;
        else     resp_count <= count_nxt;
    end
`endif

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        none_nxt    = none;
`ifdef RESOLVER_COUNT_EN
        count_nxt   = resp_count;
`endif
        case (state)
            IDLE: begin
                // abort beats start: nothing is captured
                if (start && !abort) begin
                    pending_nxt = tag_wires;
                    none_nxt    = (tag_wires == '0);
                    state_nxt   = (tag_wires == '0) ? DONE : ISSUE;
`ifdef RESOLVER_COUNT_EN
                    count_nxt   = tag_popcount;
`endif
                end
            end
            ISSUE: begin
                if (handshake) begin
                    pending_nxt = pending & ~low_bit;
`ifdef RESOLVER_COUNT_EN
                    count_nxt   = resp_count - 1'b1;
`endif
                    if (single) state_nxt = DONE;
                end
                if (abort) begin
                    pending_nxt = '0;
                    state_nxt   = IDLE;
                end
            end
            DONE: begin
                pending_nxt = '0;
                state_nxt   = IDLE;
            end
            default: begin
                pending_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end

    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign resp.resp_valid = (state == ISSUE);
    assign resp.resp_addr  = (state == ISSUE) ? first_idx : '0;
    assign resp.resp_last  = (state == ISSUE) && single;

endmodule

// File: tb/tb_response_resolver.sv
// Directed bench for response_resolver at num_cells=100; 8-bit vectors drive the low cells.
module tb_response_resolver;

    localparam int num_cells = 100;
    localparam int addr_bits = 7;

    logic                 clk_sys;
    logic                 rst;
    logic [num_cells-1:0] tag_wires;
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 none;
`ifdef RESOLVER_COUNT_EN
    logic [addr_bits:0]   resp_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    response_resolver_if #(.addr_bits(addr_bits)) resp_bus ();

    response_resolver #(
        .num_cells (num_cells),
        .addr_bits (addr_bits)
    ) dut (
        .CLK        (clk_sys),
        .RST        (rst),
        .tag_wires  (tag_wires),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .none       (none),
`ifdef RESOLVER_COUNT_EN
        .resp_count (resp_count),
`endif
        .resp       (resp_bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input int addr, input logic last,
                              input logic dn, input logic bsy);
        check({tag, "_valid"}, 32'(resp_bus.resp_valid), 32'(v));
        check({tag, "_addr"},  32'(resp_bus.resp_addr),  32'(addr));
        check({tag, "_last"},  32'(resp_bus.resp_last),  32'(last));
        check({tag, "_done"},  32'(done),                32'(dn));
        check({tag, "_busy"},  32'(busy),                32'(bsy));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    initial begin
        rst = 1'b1;
        tag_wires = '0;
        start = 1'b0;
        abort = 1'b0;
        resp_bus.resp_ready = 1'b0;
        @(negedge clk_sys);
        tick();
        tick();
        expect_out("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("reset_none", 32'(none), 32'd0);
        rst = 1'b0;
        tick();

        // three responders, consumer always ready
        tag_wires = num_cells'(8'b1010_0100);
        resp_bus.resp_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("seq_a0", 1'b1, 2, 1'b0, 1'b0, 1'b1);
`ifdef RESOLVER_COUNT_EN
        check("seq_cnt0", 32'(resp_count), 32'd3);
`endif
        tick();
        expect_out("seq_a1", 1'b1, 5, 1'b0, 1'b0, 1'b1);
`ifdef RESOLVER_COUNT_EN
        check("seq_cnt1", 32'(resp_count), 32'd2);
`endif
        tick();
        expect_out("seq_a2", 1'b1, 7, 1'b1, 1'b0, 1'b1);
`ifdef RESOLVER_COUNT_EN
        check("seq_cnt2", 32'(resp_count), 32'd1);
`endif
        tick();
        expect_out("seq_done", 1'b0, 0, 1'b0, 1'b1, 1'b1);
        check("seq_none", 32'(none), 32'd0);
`ifdef RESOLVER_COUNT_EN
        check("seq_cnt_done", 32'(resp_count), 32'd0);
`endif
        tick();
        expect_out("seq_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // empty snapshot
        tag_wires = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("empty_done", 1'b0, 0, 1'b0, 1'b1, 1'b1);
        check("empty_none", 32'(none), 32'd1);
        tick();
        expect_out("empty_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("empty_none_held", 32'(none), 32'd1);

        // backpressure: addr 0 held for four cycles
        tag_wires = num_cells'(8'b0001_0001);
        resp_bus.resp_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bp_none", 32'(none), 32'd0);
        for (int c = 0; c < 3; c++) begin
            expect_out("bp_hold", 1'b1, 0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        resp_bus.resp_ready = 1'b1;
        expect_out("bp_hold4", 1'b1, 0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("bp_a1", 1'b1, 4, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("bp_done", 1'b0, 0, 1'b0, 1'b1, 1'b1);
        tick();

        // restart and tag changes while busy are ignored
        tag_wires = num_cells'(8'b1010_0100);
        start = 1'b1;
        tick();
        tag_wires = num_cells'(8'b1111_1111);
        expect_out("busy_a0", 1'b1, 2, 1'b0, 1'b0, 1'b1);
        tick();
        tag_wires = num_cells'(8'b0000_0011);
        expect_out("busy_a1", 1'b1, 5, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("busy_a2", 1'b1, 7, 1'b1, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        expect_out("busy_done", 1'b0, 0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("busy_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // abort after the first transfer
        tag_wires = num_cells'(8'b1010_0100);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_out("abort_a1", 1'b1, 5, 1'b0, 1'b0, 1'b1);
        resp_bus.resp_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("abort_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("abort_nodone", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // abort beats start in IDLE
        tag_wires = num_cells'(8'b0000_0001);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        expect_out("abort_start", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // abort together with the final handshake still goes to IDLE
        resp_bus.resp_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("abort_hs_a0", 1'b1, 0, 1'b1, 1'b0, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("abort_hs_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // reset mid-resolution, after a none=1 snapshot
        tag_wires = '0;
        start = 1'b1;
        tick();
        tick();
        tag_wires = num_cells'(8'b1010_0100);
        tick();
        start = 1'b0;
        expect_out("rst_pre", 1'b1, 2, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst_mid", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_none", 32'(none), 32'd0);
`ifdef RESOLVER_COUNT_EN
        check("rst_mid_cnt", 32'(resp_count), 32'd0);
`endif
        tick();
        expect_out("rst_after", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // every cell tagged
        tag_wires = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < num_cells; i++) begin
            check("all_addr", 32'(resp_bus.resp_addr), 32'(i));
            check("all_last", 32'(resp_bus.resp_last), 32'(i == num_cells - 1));
            tick();
        end
        expect_out("all_done", 1'b0, 0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("all_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
